// File: rtl/ui_debounce.sv
// Two-flop synchroniser followed by a per-bit debounce counter. Each bit keeps a
// registered clean level and produces registered single-cycle rise/fall pulses.
module ui_debounce #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DB_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] clean_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    localparam logic [7:0] CNT_LAST = 8'(DB_CYCLES - 1);

    logic [WIDTH-1:0]      s1_q;
    logic [WIDTH-1:0]      s2_q;
    logic [WIDTH-1:0][7:0] cnt_q;
    logic [WIDTH-1:0][7:0] cnt_d;
    logic [WIDTH-1:0]      clean_q;
    logic [WIDTH-1:0]      clean_d;
    logic [WIDTH-1:0]      rise_q;
    logic [WIDTH-1:0]      rise_d;
    logic [WIDTH-1:0]      fall_q;
    logic [WIDTH-1:0]      fall_d;
    logic                  changed_q;
    logic                  changed_d;

    always_comb begin
        cnt_d   = '0;
        clean_d = clean_q;
        rise_d  = '0;
        fall_d  = '0;
        if (ena) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (s2_q[i] == clean_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    clean_d[i] = s2_q[i];
                    rise_d[i]  = s2_q[i];
                    fall_d[i]  = ~s2_q[i];
                    cnt_d[i]   = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 8'd1;
                end
            end
        end
        // Pulses and changed are registered together so they share one cycle.
        changed_d = |(rise_d | fall_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q      <= '0;
            s2_q      <= '0;
            cnt_q     <= '0;
            clean_q   <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            s1_q      <= raw_in;
            s2_q      <= s1_q;
            cnt_q     <= cnt_d;
            clean_q   <= clean_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
        end
    end

    assign clean_out = clean_q;
    assign rise      = rise_q;
    assign fall      = fall_q;
    assign changed   = changed_q;

endmodule

// File: tb/tb_ui_debounce.sv
// Self-checking bench for ui_debounce: directed scenarios plus randomized
// stimulus compared against a sliding-window reference model.
module tb_ui_debounce;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b1;
    logic [7:0] raw_in = 8'h00;
    logic [7:0] clean_out;
    logic [7:0] rise;
    logic [7:0] fall;
    logic       changed;

    int checks = 0;
    int errors = 0;

    ui_debounce #(.WIDTH(8), .DB_CYCLES(DB)) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .raw_in    (raw_in),
        .clean_out (clean_out),
        .rise      (rise),
        .fall      (fall),
        .changed   (changed)
    );

    always #5 clk = ~clk;

    // Reference: a bit flips when the last DB synchronised samples all differ
    // from its clean level and ena was high for every one of those edges.
    bit [7:0] hist[$];
    bit [7:0] win_s[$];
    bit       win_e[$];
    bit [7:0] m_clean, m_rise, m_fall;
    bit       m_changed;

    always @(posedge clk or posedge rst) begin
        bit [7:0] sync;
        bit [7:0] flips;
        bit       all;
        if (rst) begin
            hist.delete();
            win_s.delete();
            win_e.delete();
            m_clean   = '0;
            m_rise    = '0;
            m_fall    = '0;
            m_changed = 1'b0;
        end else begin
            sync = (hist.size() == 2) ? hist[0] : 8'h00;
            hist.push_back(raw_in);
            if (hist.size() > 2) void'(hist.pop_front());
            win_s.push_back(sync);
            win_e.push_back(ena);
            if (win_s.size() > DB) begin
                void'(win_s.pop_front());
                void'(win_e.pop_front());
            end
            flips = '0;
            if (win_s.size() == DB) begin
                for (int b = 0; b < 8; b++) begin
                    all = 1'b1;
                    for (int j = 0; j < DB; j++)
                        if (!win_e[j] || win_s[j][b] == m_clean[b]) all = 1'b0;
                    flips[b] = all;
                end
            end
            m_rise    = flips & ~m_clean;
            m_fall    = flips & m_clean;
            m_clean   = m_clean ^ flips;
            m_changed = |flips;
        end
    end

    task automatic test_reset();
        logic [7:0] ec, er;
        rst = 1'b1; ena = 1'b1; raw_in = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (clean_out !== 8'h00) begin errors++; $display("FAIL reset_clean got %h want 00", clean_out); end
        checks++; if (rise !== 8'h00) begin errors++; $display("FAIL reset_rise got %h want 00", rise); end
        checks++; if (fall !== 8'h00) begin errors++; $display("FAIL reset_fall got %h want 00", fall); end
        checks++; if (changed !== 1'b0) begin errors++; $display("FAIL reset_changed got %b want 0", changed); end
        @(negedge clk) rst = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk); #1;
            ec = (e >= 6) ? 8'hFF : 8'h00;
            er = (e == 6) ? 8'hFF : 8'h00;
            checks++; if (clean_out !== ec) begin errors++; $display("FAIL release_clean e%0d got %h want %h", e, clean_out, ec); end
            checks++; if (rise !== er) begin errors++; $display("FAIL release_rise e%0d got %h want %h", e, rise, er); end
            checks++; if (changed !== (e == 6)) begin errors++; $display("FAIL release_changed e%0d got %b want %b", e, changed, e == 6); end
        end
    endtask

    task automatic test_clean_step();
        @(negedge clk) raw_in = 8'h00;
        repeat (10) @(posedge clk);
        @(negedge clk) raw_in = 8'h01;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk); #1;
            checks++; if (clean_out !== ((e >= 6) ? 8'h01 : 8'h00)) begin errors++; $display("FAIL step_up_clean e%0d got %h", e, clean_out); end
            checks++; if (rise !== ((e == 6) ? 8'h01 : 8'h00)) begin errors++; $display("FAIL step_up_rise e%0d got %h want %h", e, rise, (e == 6) ? 8'h01 : 8'h00); end
        end
        @(negedge clk) raw_in = 8'h00;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk); #1;
            checks++; if (clean_out !== ((e >= 6) ? 8'h00 : 8'h01)) begin errors++; $display("FAIL step_down_clean e%0d got %h", e, clean_out); end
            checks++; if (fall !== ((e == 6) ? 8'h01 : 8'h00)) begin errors++; $display("FAIL step_down_fall e%0d got %h want %h", e, fall, (e == 6) ? 8'h01 : 8'h00); end
            checks++; if (rise !== 8'h00) begin errors++; $display("FAIL step_down_rise e%0d got %h want 00", e, rise); end
        end
    endtask

    task automatic test_glitch(input int hold);
        logic [7:0] ec, er, ef;
        for (int e = 1; e <= 12; e++) begin
            @(negedge clk) raw_in = (e <= hold) ? 8'h08 : 8'h00;
            @(posedge clk); #1;
            ec = (hold >= DB && e >= 6 && e <= 9) ? 8'h08 : 8'h00;
            er = (hold >= DB && e == 6) ? 8'h08 : 8'h00;
            ef = (hold >= DB && e == 10) ? 8'h08 : 8'h00;
            checks++; if (clean_out !== ec) begin errors++; $display("FAIL glitch%0d_clean e%0d got %h want %h", hold, e, clean_out, ec); end
            checks++; if (rise !== er || fall !== ef) begin errors++; $display("FAIL glitch%0d_pulse e%0d got r%h f%h want r%h f%h", hold, e, rise, fall, er, ef); end
        end
    endtask

    task automatic test_enable();
        logic [7:0] ec, er;
        for (int e = 1; e <= 22; e++) begin
            @(negedge clk) begin
                raw_in = 8'h20;
                ena = !(e >= 5 && e <= 14);
            end
            @(posedge clk); #1;
            ec = (e >= 18) ? 8'h20 : 8'h00;
            er = (e == 18) ? 8'h20 : 8'h00;
            checks++; if (clean_out !== ec) begin errors++; $display("FAIL enable_clean e%0d got %h want %h", e, clean_out, ec); end
            checks++; if (rise !== er || changed !== (e == 18)) begin errors++; $display("FAIL enable_pulse e%0d got r%h c%b want r%h", e, rise, changed, er); end
        end
        @(negedge clk) begin raw_in = 8'h00; ena = 1'b1; end
        repeat (10) @(posedge clk);
    endtask

    task automatic test_back_to_back();
        @(negedge clk) raw_in = 8'hA5;
        for (int e = 1; e <= 7; e++) begin
            @(posedge clk); #1;
            checks++; if (clean_out !== ((e >= 6) ? 8'hA5 : 8'h00)) begin errors++; $display("FAIL simul_clean e%0d got %h", e, clean_out); end
            checks++; if (rise !== ((e == 6) ? 8'hA5 : 8'h00)) begin errors++; $display("FAIL simul_rise e%0d got %h", e, rise); end
        end
        @(negedge clk) raw_in = 8'h00;
        repeat (4) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checks++; if (clean_out !== 8'h00 || rise !== 8'h00 || fall !== 8'h00 || changed !== 1'b0) begin
            errors++; $display("FAIL async_rst got c%h r%h f%h ch%b want zeros", clean_out, rise, fall, changed);
        end
        @(negedge clk) rst = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk); #1;
            checks++; if (clean_out !== 8'h00 || rise !== 8'h00 || fall !== 8'h00 || changed !== 1'b0) begin
                errors++; $display("FAIL post_rst e%0d got c%h r%h f%h ch%b want zeros", e, clean_out, rise, fall, changed);
            end
        end
    endtask

    task automatic test_random();
        int       hold[8];
        bit [7:0] r;
        r = '0;
        for (int b = 0; b < 8; b++) hold[b] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk) begin
                for (int b = 0; b < 8; b++) begin
                    if (hold[b] == 0) begin
                        r[b]    = 1'($urandom_range(0, 1));
                        hold[b] = $urandom_range(1, 7);
                    end
                    hold[b]--;
                end
                raw_in = r;
                ena = ($urandom_range(0, 15) != 0);
            end
            @(posedge clk); #1;
            checks++; if (clean_out !== m_clean) begin errors++; $display("FAIL rand_clean c%0d got %h want %h", cyc, clean_out, m_clean); end
            checks++; if (rise !== m_rise || fall !== m_fall) begin errors++; $display("FAIL rand_pulse c%0d got r%h f%h want r%h f%h", cyc, rise, fall, m_rise, m_fall); end
            checks++; if (changed !== m_changed) begin errors++; $display("FAIL rand_changed c%0d got %b want %b", cyc, changed, m_changed); end
        end
    endtask

    initial begin
        test_reset();
        test_clean_step();
        test_glitch(3);
        test_glitch(4);
        test_enable();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
